alu_issue_stage: RTL and testbench

Operand-issue and writeback stage wrapped around the combinational `processor_alu`. It holds an 8 x 32 register file and accepts 3-operand instructions over a valid/ready handshake. Each instruction's operands are read (with forwarding) into an execute register that drives the ALU's A/B/aluctrl, and the ALU's Z is written back to the register file one cycle later. It also keeps a sticky overflow flag and counter, and gives a host read/write port for loading and inspecting registers.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_issue_stage_if.sv | 13 +
 rtl/alu_regfile.sv | 37 +++
 rtl/processor_alu.sv | 31 +++
 rtl/alu_issue_stage.sv | 94 +++++++++
 tb/tb_alu_issue_stage.sv | 273 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and datapath widths for the ALU issue/writeback slice.
package alu_pkg;
   localparam int unsigned REG_W  = 32;
   localparam int unsigned RIDX_W = 3;

   localparam logic [2:0] ALU_OP_ADD = 3'b000;
   localparam logic [2:0] ALU_OP_SUB = 3'b001;
   localparam logic [2:0] ALU_OP_AND = 3'b010;
   localparam logic [2:0] ALU_OP_OR  = 3'b011;
   localparam logic [2:0] ALU_OP_XOR = 3'b100;
   localparam logic [2:0] ALU_OP_NOR = 3'b101;
   localparam logic [2:0] ALU_OP_SLT = 3'b110;
   localparam logic [2:0] ALU_OP_SLL = 3'b111;
endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction issue handshake: valid/ready plus opcode and register indices.
interface alu_issue_stage_if;
   import alu_pkg::*;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_op;
   logic [RIDX_W-1:0] in_rd;
   logic [RIDX_W-1:0] in_rs;
   logic [RIDX_W-1:0] in_rt;

   modport master (output in_valid, in_op, in_rd, in_rs, in_rt, input in_ready);
   modport slave  (input in_valid, in_op, in_rd, in_rs, in_rt, output in_ready);
endinterface

// File: rtl/alu_regfile.sv
// 8x32 register file: r0 reads zero, three async reads, host write beats writeback.
module alu_regfile
   import alu_pkg::*;
#(
   parameter int unsigned NREG = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [RIDX_W-1:0] rs_addr,
   output logic [REG_W-1:0]  rs_data,
   input  logic [RIDX_W-1:0] rt_addr,
   output logic [REG_W-1:0]  rt_data,
   input  logic [RIDX_W-1:0] cfg_raddr,
   output logic [REG_W-1:0]  cfg_rdata,
   input  logic              wb_we,
   input  logic [RIDX_W-1:0] wb_addr,
   input  logic [REG_W-1:0]  wb_data,
   input  logic              cfg_we,
   input  logic [RIDX_W-1:0] cfg_waddr,
   input  logic [REG_W-1:0]  cfg_wdata
);
   logic [REG_W-1:0] rf [NREG];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
      end else begin
         // Host write is issued last so it overrides a same-register writeback.
         if (wb_we && (wb_addr != '0))    rf[wb_addr]   <= wb_data;
         if (cfg_we && (cfg_waddr != '0)) rf[cfg_waddr] <= cfg_wdata;
      end
   end

   assign rs_data   = (rs_addr   == '0) ? '0 : rf[rs_addr];
   assign rt_data   = (rt_addr   == '0) ? '0 : rf[rt_addr];
   assign cfg_rdata = (cfg_raddr == '0) ? '0 : rf[cfg_raddr];
endmodule

// File: rtl/processor_alu.sv
// Combinational 32-bit ALU; overflow reported for signed add/sub only.
module processor_alu
   import alu_pkg::*;
(
   input  logic [REG_W-1:0] A,
   input  logic [REG_W-1:0] B,
   input  logic [2:0]       aluctrl,
   output logic [REG_W-1:0] Z,
   output logic             overflow
);
   always_comb begin
      Z        = '0;
      overflow = 1'b0;
      case (aluctrl)
         ALU_OP_ADD: begin
            Z        = A + B;
            overflow = (A[REG_W-1] == B[REG_W-1]) && (Z[REG_W-1] != A[REG_W-1]);
         end
         ALU_OP_SUB: begin
            Z        = A - B;
            overflow = (A[REG_W-1] != B[REG_W-1]) && (Z[REG_W-1] != A[REG_W-1]);
         end
         ALU_OP_AND: Z = A & B;
         ALU_OP_OR:  Z = A | B;
         ALU_OP_XOR: Z = A ^ B;
         ALU_OP_NOR: Z = ~(A | B);
         ALU_OP_SLT: Z = {{(REG_W-1){1'b0}}, ($signed(A) < $signed(B))};
         default:    Z = A << B[4:0];
      endcase
   end
endmodule

// File: rtl/alu_issue_stage.sv
// Operand issue with forwarding into an EX register feeding processor_alu, plus
// writeback into the register file and sticky/saturating overflow accounting.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int unsigned NREG  = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   alu_issue_stage_if.slave  issue,
   output logic [REG_W-1:0]  alu_a,
   output logic [REG_W-1:0]  alu_b,
   output logic [2:0]        alu_ctrl,
   input  logic [REG_W-1:0]  alu_z,
   input  logic              alu_overflow,
   output logic              wb_valid,
   output logic [RIDX_W-1:0] wb_rd,
   output logic [REG_W-1:0]  wb_data,
   input  logic              cfg_we,
   input  logic [RIDX_W-1:0] cfg_waddr,
   input  logic [REG_W-1:0]  cfg_wdata,
   input  logic [RIDX_W-1:0] cfg_raddr,
   output logic [REG_W-1:0]  cfg_rdata,
   output logic              ovf_flag,
   output logic [CNT_W-1:0]  ovf_count,
   input  logic              ovf_clr
);
   logic              ex_valid;
   logic [RIDX_W-1:0] ex_rd;
   logic [REG_W-1:0]  rs_data, rt_data, op_a, op_b;
   logic              accept, ovf_hit;

   alu_regfile #(.NREG(NREG)) u_rf (
      .clk(clk), .reset(reset),
      .rs_addr(issue.in_rs), .rs_data(rs_data),
      .rt_addr(issue.in_rt), .rt_data(rt_data),
      .cfg_raddr(cfg_raddr), .cfg_rdata(cfg_rdata),
      .wb_we(ex_valid), .wb_addr(ex_rd), .wb_data(alu_z),
      .cfg_we(cfg_we), .cfg_waddr(cfg_waddr), .cfg_wdata(cfg_wdata)
   );

   function automatic logic [REG_W-1:0] operand(input logic [RIDX_W-1:0] idx,
                                                input logic [REG_W-1:0]  rf_val);
      if (idx == '0)                           return '0;
      else if (ex_valid && (ex_rd == idx))     return alu_z;
      else if (cfg_we && (cfg_waddr == idx))   return cfg_wdata;
      else                                     return rf_val;
   endfunction

   always_comb begin
      op_a = operand(issue.in_rs, rs_data);
      op_b = operand(issue.in_rt, rt_data);
   end

   assign issue.in_ready = ~cfg_we;
   assign accept         = issue.in_valid & issue.in_ready;
   assign ovf_hit        = ex_valid & alu_overflow;
   assign wb_valid       = ex_valid;
   assign wb_rd          = ex_rd;
   assign wb_data        = alu_z;

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid <= 1'b0;
         ex_rd    <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_ctrl <= '0;
      end else begin
         ex_valid <= accept;
         if (accept) begin
            ex_rd    <= issue.in_rd;
            alu_a    <= op_a;
            alu_b    <= op_b;
            alu_ctrl <= issue.in_op;
         end
      end
   end

   // A clear coinciding with a counted overflow restarts the count at one.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_flag  <= 1'b0;
         ovf_count <= '0;
      end else if (ovf_clr) begin
         ovf_flag  <= ovf_hit;
         ovf_count <= ovf_hit ? CNT_W'(1) : '0;
      end else if (ovf_hit) begin
         ovf_flag <= 1'b1;
         if (ovf_count != '1) ovf_count <= ovf_count + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage paired with processor_alu.
module tb_alu_issue_stage;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] alu_a, alu_b, alu_z, wb_data, cfg_wdata, cfg_rdata;
   logic [2:0]  alu_ctrl, wb_rd, cfg_waddr, cfg_raddr;
   logic        alu_ovf_raw, force_ovf, alu_overflow, wb_valid, cfg_we;
   logic        ovf_flag, ovf_clr;
   logic [15:0] ovf_count;
   int          vec = 0;
   int          miscmp = 0;

   alu_issue_stage_if issue_if ();

   assign alu_overflow = alu_ovf_raw | force_ovf;

   alu_issue_stage #(.NREG(8), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .issue(issue_if.slave),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_z(alu_z), .alu_overflow(alu_overflow),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .cfg_we(cfg_we), .cfg_waddr(cfg_waddr), .cfg_wdata(cfg_wdata),
      .cfg_raddr(cfg_raddr), .cfg_rdata(cfg_rdata),
      .ovf_flag(ovf_flag), .ovf_count(ovf_count), .ovf_clr(ovf_clr)
   );

   processor_alu u_alu (
      .A(alu_a), .B(alu_b), .aluctrl(alu_ctrl), .Z(alu_z), .overflow(alu_ovf_raw)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host_write(input logic [2:0] r, input logic [31:0] d);
      cfg_we = 1'b1; cfg_waddr = r; cfg_wdata = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic issue(input logic [2:0] op, rd, rs, rt);
      issue_if.in_valid = 1'b1;
      issue_if.in_op = op; issue_if.in_rd = rd; issue_if.in_rs = rs; issue_if.in_rt = rt;
   endtask

   task automatic read_reg(input logic [2:0] r, input logic [31:0] exp, input string name);
      cfg_raddr = r;
      #1;
      vec++;
      if (cfg_rdata !== exp) begin
         miscmp++;
         $display("FAIL %s: r%0d got %h expected %h", name, r, cfg_rdata, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      vec++;
      if ({alu_a, alu_b, alu_ctrl} !== 67'd0) begin
         miscmp++; $display("FAIL reset_ex: got a=%h b=%h ctrl=%h expected 0", alu_a, alu_b, alu_ctrl);
      end
      vec++;
      if ({wb_valid, wb_rd, ovf_flag, ovf_count} !== 21'd0) begin
         miscmp++;
         $display("FAIL reset_misc: got wbv=%b rd=%0d flag=%b cnt=%h expected 0", wb_valid, wb_rd, ovf_flag, ovf_count);
      end
      vec++;
      if (issue_if.in_ready !== 1'b1) begin
         miscmp++; $display("FAIL reset_ready: got %b expected 1", issue_if.in_ready);
      end
      for (int r = 1; r < 8; r++) read_reg(3'(r), 32'd0, "reset_rf");
   endtask

   task automatic test_load_add();
      host_write(3'd1, 32'h0123);
      host_write(3'd2, 32'h2222);
      issue(ALU_OP_ADD, 3'd3, 3'd1, 3'd2);
      tick();
      issue_if.in_valid = 1'b0;
      vec++;
      if (alu_a !== 32'h0123 || alu_b !== 32'h2222) begin
         miscmp++; $display("FAIL load_add_ops: got a=%h b=%h expected 00000123 00002222", alu_a, alu_b);
      end
      vec++;
      if (wb_valid !== 1'b1 || wb_rd !== 3'd3 || wb_data !== 32'h2345) begin
         miscmp++; $display("FAIL load_add_wb: got v=%b rd=%0d d=%h expected 1 3 00002345", wb_valid, wb_rd, wb_data);
      end
      tick();
      read_reg(3'd3, 32'h2345, "load_add_r3");
   endtask

   task automatic test_forwarding();
      host_write(3'd1, 32'd5);
      host_write(3'd2, 32'd7);
      issue(ALU_OP_ADD, 3'd3, 3'd1, 3'd2);
      tick();
      issue(ALU_OP_ADD, 3'd4, 3'd3, 3'd3);
      vec++;
      if (alu_a !== 32'd5 || alu_b !== 32'd7) begin
         miscmp++; $display("FAIL fwd_first: got a=%h b=%h expected 5 7", alu_a, alu_b);
      end
      tick();
      issue_if.in_valid = 1'b0;
      vec++;
      if (alu_a !== 32'd12 || alu_b !== 32'd12 || wb_valid !== 1'b1 || wb_rd !== 3'd4) begin
         miscmp++;
         $display("FAIL fwd_second: got a=%h b=%h v=%b rd=%0d expected 12 12 1 4", alu_a, alu_b, wb_valid, wb_rd);
      end
      tick();
      vec++;
      if (wb_valid !== 1'b0) begin
         miscmp++; $display("FAIL fwd_idle: got wb_valid=%b expected 0", wb_valid);
      end
      read_reg(3'd3, 32'd12, "fwd_r3");
      read_reg(3'd4, 32'd24, "fwd_r4");
   endtask

   task automatic test_r0_collision();
      issue(ALU_OP_ADD, 3'd0, 3'd1, 3'd2);
      tick();
      issue_if.in_valid = 1'b0;
      tick();
      read_reg(3'd0, 32'd0, "r0_write");
      issue(ALU_OP_ADD, 3'd0, 3'd0, 3'd1);
      tick();
      issue_if.in_valid = 1'b0;
      vec++;
      if (alu_a !== 32'd0 || alu_b !== 32'd5) begin
         miscmp++; $display("FAIL r0_read: got a=%h b=%h expected 0 5", alu_a, alu_b);
      end
      issue(ALU_OP_ADD, 3'd5, 3'd1, 3'd2);
      tick();
      issue_if.in_valid = 1'b0;
      vec++;
      if (wb_valid !== 1'b1 || wb_rd !== 3'd5) begin
         miscmp++; $display("FAIL collide_wb: got v=%b rd=%0d expected 1 5", wb_valid, wb_rd);
      end
      host_write(3'd5, 32'hDEAD);
      read_reg(3'd5, 32'hDEAD, "collide_r5");
   endtask

   task automatic test_handshake();
      issue(ALU_OP_ADD, 3'd6, 3'd1, 3'd2);
      cfg_we = 1'b1; cfg_waddr = 3'd7; cfg_wdata = 32'h77;
      for (int i = 0; i < 3; i++) begin
         #1;
         vec++;
         if (issue_if.in_ready !== 1'b0) begin
            miscmp++; $display("FAIL hs_ready: cycle %0d got %b expected 0", i, issue_if.in_ready);
         end
         tick();
         vec++;
         if (wb_valid !== 1'b0) begin
            miscmp++; $display("FAIL hs_noaccept: cycle %0d got wb_valid=%b expected 0", i, wb_valid);
         end
      end
      cfg_we = 1'b0;
      issue_if.in_valid = 1'b0;
      tick();
      vec++;
      if (wb_valid !== 1'b0) begin
         miscmp++; $display("FAIL hs_after: got wb_valid=%b expected 0", wb_valid);
      end
      read_reg(3'd6, 32'd0, "hs_r6");
      read_reg(3'd7, 32'h77, "hs_r7");
   endtask

   task automatic test_overflow();
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      vec++;
      if (ovf_flag !== 1'b0 || ovf_count !== 16'd0) begin
         miscmp++; $display("FAIL ovf_clr_idle: got flag=%b cnt=%h expected 0 0", ovf_flag, ovf_count);
      end
      force_ovf = 1'b1;
      issue(ALU_OP_ADD, 3'd0, 3'd0, 3'd0);
      tick(); tick(); tick();
      issue_if.in_valid = 1'b0;
      tick();
      vec++;
      if (ovf_flag !== 1'b1 || ovf_count !== 16'd3) begin
         miscmp++; $display("FAIL ovf_three: got flag=%b cnt=%h expected 1 0003", ovf_flag, ovf_count);
      end
      issue(ALU_OP_ADD, 3'd0, 3'd0, 3'd0);
      tick();
      issue_if.in_valid = 1'b0;
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      vec++;
      if (ovf_flag !== 1'b1 || ovf_count !== 16'd1) begin
         miscmp++; $display("FAIL ovf_clr_hit: got flag=%b cnt=%h expected 1 0001", ovf_flag, ovf_count);
      end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      vec++;
      if (ovf_flag !== 1'b0 || ovf_count !== 16'd0) begin
         miscmp++; $display("FAIL ovf_clr_plain: got flag=%b cnt=%h expected 0 0", ovf_flag, ovf_count);
      end
      issue(ALU_OP_ADD, 3'd0, 3'd0, 3'd0);
      for (int i = 0; i < 65535; i++) tick();
      issue_if.in_valid = 1'b0;
      tick();
      vec++;
      if (ovf_count !== 16'hFFFF) begin
         miscmp++; $display("FAIL ovf_fill: got cnt=%h expected ffff", ovf_count);
      end
      issue(ALU_OP_ADD, 3'd0, 3'd0, 3'd0);
      tick();
      issue_if.in_valid = 1'b0;
      tick();
      vec++;
      if (ovf_count !== 16'hFFFF || ovf_flag !== 1'b1) begin
         miscmp++; $display("FAIL ovf_sat: got flag=%b cnt=%h expected 1 ffff", ovf_flag, ovf_count);
      end
      force_ovf = 1'b0;
   endtask

   task automatic test_reset_midop();
      issue(ALU_OP_ADD, 3'd6, 3'd1, 3'd2);
      tick();
      vec++;
      if (wb_valid !== 1'b1 || wb_rd !== 3'd6) begin
         miscmp++; $display("FAIL midop_ex: got v=%b rd=%0d expected 1 6", wb_valid, wb_rd);
      end
      reset = 1'b1;
      cfg_we = 1'b1; cfg_waddr = 3'd2; cfg_wdata = 32'h1234;
      #1;
      vec++;
      if (issue_if.in_ready !== 1'b0) begin
         miscmp++; $display("FAIL midop_ready: got %b expected 0", issue_if.in_ready);
      end
      tick();
      cfg_we = 1'b0;
      reset = 1'b0;
      issue_if.in_valid = 1'b0;
      vec++;
      if ({wb_valid, wb_rd, alu_a, alu_b, alu_ctrl, ovf_flag, ovf_count} !== 88'd0) begin
         miscmp++;
         $display("FAIL midop_outs: got v=%b rd=%0d a=%h b=%h ctrl=%h flag=%b cnt=%h expected 0",
                  wb_valid, wb_rd, alu_a, alu_b, alu_ctrl, ovf_flag, ovf_count);
      end
      read_reg(3'd6, 32'd0, "midop_r6");
      read_reg(3'd2, 32'd0, "midop_r2");
      read_reg(3'd1, 32'd0, "midop_r1");
   endtask

   initial begin
      reset = 1'b1; force_ovf = 1'b0; ovf_clr = 1'b0;
      cfg_we = 1'b0; cfg_waddr = '0; cfg_wdata = '0; cfg_raddr = '0;
      issue_if.in_valid = 1'b0; issue_if.in_op = '0;
      issue_if.in_rd = '0; issue_if.in_rs = '0; issue_if.in_rt = '0;
      #1;
      test_reset();
      test_load_add();
      test_forwarding();
      test_r0_collision();
      test_handshake();
      test_overflow();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
      $finish;
   end
endmodule
